// File: rtl/gpu2d_pkg.sv
// gpu2d_pkg: shared types and constants for the 2D line-write path.
//   - sched_state_e : scheduler FSM states (IDLE, START, RUN, DONE)
//   - VRAM_ADDR_W   : line-buffer address width
//   - VRAM_DATA_W   : line-buffer pixel data width
//   - sat_inc8      : saturating 8-bit increment used by the event counters
package gpu2d_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/line_write_scheduler_if.sv
// line_write_scheduler_if: render-requester write bus.
//   req_valid[NUM_REQ]            : per-requester write valid
//   req_last[NUM_REQ]             : final write of the line for that requester
//   req_addr[NUM_REQ*VRAM_ADDR_W] : packed pixel addresses
//   req_data[NUM_REQ*VRAM_DATA_W] : packed pixel data
//   req_ready[NUM_REQ]            : one-hot grant from the scheduler
// Modports: master = render units, slave = scheduler.
interface line_write_scheduler_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                          req_valid;
  logic [NUM_REQ-1:0]                          req_last;
  logic [NUM_REQ*gpu2d_pkg::VRAM_ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*gpu2d_pkg::VRAM_DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]                          req_ready;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready
  );

endinterface

// File: rtl/line_write_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req[N]       : request vector (already masked by the scheduler)
//   ptr[PTR_W]   : highest-priority index for this cycle
//   grant[N]     : one-hot grant, zero when no request is pending
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found_s;

  // Scan from ptr upward (wrapping) and grant the first requester found.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found_s && req[idx]) begin
        grant[idx] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/line_write_scheduler.sv
// line_write_scheduler: launches render requesters at each scanline start,
// grants the single VRAM write port round-robin and steers accepted writes
// to the even or odd line bank.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   line_start/line_no_in/
//   render_bank                : scanline start pulse with line number and target bank
//   req_bus (slave)            : requester valid/last/addr/data, ready (one-hot grant)
//   line_go                    : one-cycle pulse, requesters may start
//   line_no                    : latched scanline number
//   line_done                  : one-cycle pulse, every requester delivered its last beat
//   overrun_cnt                : saturating count of lines aborted by a new line_start
//   oob_cnt                    : saturating count of dropped out-of-range writes
//   vram_even_* / vram_odd_*   : bank write ports (one-cycle write latency)
// Build option: LINE_SCHED_BOUNDS_CHECK_EN drops writes with addr >= LINE_WIDTH
// and counts them in oob_cnt; otherwise addresses pass through and oob_cnt is 0.
module line_write_scheduler
  import gpu2d_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LINE_WIDTH = 800,
  parameter int LINE_NO_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [LINE_NO_W-1:0]   line_no_in,
  input  logic                   render_bank,
  line_write_scheduler_if.slave  req_bus,
  output logic                   line_go,
  output logic [LINE_NO_W-1:0]   line_no,
  output logic                   line_done,
  output logic [7:0]             overrun_cnt,
  output logic [7:0]             oob_cnt,
  output logic                   vram_even_we,
  output logic [VRAM_ADDR_W-1:0] vram_even_addr,
  output logic [VRAM_DATA_W-1:0] vram_even_d,
  output logic                   vram_odd_we,
  output logic [VRAM_ADDR_W-1:0] vram_odd_addr,
  output logic [VRAM_DATA_W-1:0] vram_odd_d
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e             state_r;
  logic [PTR_W-1:0]         ptr_r;
  logic [NUM_REQ-1:0]       finished_r;
  logic                     bank_r;

  logic [NUM_REQ-1:0]       arb_req_s;
  logic [NUM_REQ-1:0]       grant_s;
  logic [NUM_REQ-1:0]       fin_next_s;
  logic [PTR_W-1:0]         gidx_s;
  logic [PTR_W-1:0]         next_ptr_s;
  logic [VRAM_ADDR_W-1:0]   sel_addr_s;
  logic [VRAM_DATA_W-1:0]   sel_data_s;
  logic                     sel_last_s;
  logic                     xfer_s;
  logic                     oob_s;
  logic                     write_en_s;

  // A line_start cycle never grants, so the aborted line cannot sneak a write in.
  assign arb_req_s = req_bus.req_valid & ~finished_r
                   & {NUM_REQ{(state_r == RUN) && !line_start}};

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (arb_req_s),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  assign req_bus.req_ready = grant_s;
  assign xfer_s            = |grant_s;

  // Encode the grant and mux the winning requester's beat.
  always_comb begin
    gidx_s     = '0;
    sel_addr_s = '0;
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        gidx_s     = PTR_W'(i);
        sel_addr_s = req_bus.req_addr[i*VRAM_ADDR_W +: VRAM_ADDR_W];
        sel_data_s = req_bus.req_data[i*VRAM_DATA_W +: VRAM_DATA_W];
        sel_last_s = req_bus.req_last[i];
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  // Finished flags after this cycle's transfer, and the pointer just past the winner.
  always_comb begin
    fin_next_s = finished_r | (sel_last_s ? grant_s : '0);
    if (gidx_s == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gidx_s + PTR_W'(1);
    end
  end

`ifdef LINE_SCHED_BOUNDS_CHECK_EN
  localparam logic [VRAM_ADDR_W:0] LINE_WIDTH_C = LINE_WIDTH[VRAM_ADDR_W:0];
  logic [7:0] oob_cnt_r;

  assign oob_s = xfer_s && ({1'b0, sel_addr_s} >= LINE_WIDTH_C);

  // Out-of-range beats complete their handshake but only bump this counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_cnt_r <= 8'd0;
    end else if (oob_s) begin
      oob_cnt_r <= sat_inc8(oob_cnt_r);
    end
  end

  assign oob_cnt = oob_cnt_r;
`else
  assign oob_s   = 1'b0;
  assign oob_cnt = 8'd0;
`endif

  assign write_en_s = xfer_s && !oob_s;

  // Scheduler FSM with registered pulses and bank write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      finished_r     <= '0;
      bank_r         <= 1'b0;
      line_go        <= 1'b0;
      line_no        <= '0;
      line_done      <= 1'b0;
      overrun_cnt    <= 8'd0;
      vram_even_we   <= 1'b0;
      vram_even_addr <= '0;
      vram_even_d    <= '0;
      vram_odd_we    <= 1'b0;
      vram_odd_addr  <= '0;
      vram_odd_d     <= '0;
    end else begin
      line_go        <= 1'b0;
      line_done      <= 1'b0;
      vram_even_we   <= 1'b0;
      vram_even_addr <= '0;
      vram_even_d    <= '0;
      vram_odd_we    <= 1'b0;
      vram_odd_addr  <= '0;
      vram_odd_d     <= '0;
      if (line_start) begin
        // A start while a line is still in flight aborts that line.
        if ((state_r == START) || (state_r == RUN)) begin
          overrun_cnt <= sat_inc8(overrun_cnt);
        end
        state_r    <= START;
        line_no    <= line_no_in;
        bank_r     <= render_bank;
        finished_r <= '0;
        ptr_r      <= '0;
        line_go    <= 1'b1;
      end else begin
        case (state_r)
          IDLE:  state_r <= IDLE;
          START: state_r <= RUN;
          RUN: begin
            if (xfer_s) begin
              ptr_r      <= next_ptr_s;
              finished_r <= fin_next_s;
              if (write_en_s) begin
                if (bank_r) begin
                  vram_odd_we   <= 1'b1;
                  vram_odd_addr <= sel_addr_s;
                  vram_odd_d    <= sel_data_s;
                end else begin
                  vram_even_we   <= 1'b1;
                  vram_even_addr <= sel_addr_s;
                  vram_even_d    <= sel_data_s;
                end
              end
              if (&fin_next_s) begin
                state_r   <= DONE;
                line_done <= 1'b1;
              end
            end
          end
          DONE:    state_r <= DONE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_write_scheduler.sv
// Directed self-checking bench for line_write_scheduler (NUM_REQ=2).
module tb_line_write_scheduler;
  import gpu2d_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        line_start;
  logic [9:0]  line_no_in;
  logic        render_bank;
  logic        line_go;
  logic [9:0]  line_no;
  logic        line_done;
  logic [7:0]  overrun_cnt;
  logic [7:0]  oob_cnt;
  logic        vram_even_we;
  logic [9:0]  vram_even_addr;
  logic [7:0]  vram_even_d;
  logic        vram_odd_we;
  logic [9:0]  vram_odd_addr;
  logic [7:0]  vram_odd_d;

  int checks_cnt;
  int fail_cnt;

  line_write_scheduler_if #(.NUM_REQ(2)) bus ();

  line_write_scheduler #(.NUM_REQ(2), .LINE_WIDTH(800), .LINE_NO_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .line_start     (line_start),
    .line_no_in     (line_no_in),
    .render_bank    (render_bank),
    .req_bus        (bus),
    .line_go        (line_go),
    .line_no        (line_no),
    .line_done      (line_done),
    .overrun_cnt    (overrun_cnt),
    .oob_cnt        (oob_cnt),
    .vram_even_we   (vram_even_we),
    .vram_even_addr (vram_even_addr),
    .vram_even_d    (vram_even_d),
    .vram_odd_we    (vram_odd_we),
    .vram_odd_addr  (vram_odd_addr),
    .vram_odd_d     (vram_odd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] l,
                         input logic [9:0] a0, input logic [7:0] d0,
                         input logic [9:0] a1, input logic [7:0] d1);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  // Hand-derived: grants alternate, beats advance per requester.
  logic [1:0] gtab [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [9:0] atab [6] = '{10'd0, 10'd100, 10'd1, 10'd101, 10'd2, 10'd102};
  logic [7:0] dtab [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};

  initial begin
    int         beat [2];
    logic [1:0] fin_m;
    checks_cnt  = 0;
    fail_cnt    = 0;
    rst_n       = 1'b0;
    line_start  = 1'b0;
    line_no_in  = 10'd0;
    render_bank = 1'b0;
    set_req(2'b00, 2'b00, 10'd0, 8'd0, 10'd0, 8'd0);

    // Reset state
    tick();
    tick();
    check_val("rst_line_go",  32'(line_go), 32'd0);
    check_val("rst_line_no",  32'(line_no), 32'd0);
    check_val("rst_done",     32'(line_done), 32'd0);
    check_val("rst_overrun",  32'(overrun_cnt), 32'd0);
    check_val("rst_oob",      32'(oob_cnt), 32'd0);
    check_val("rst_even_we",  32'(vram_even_we), 32'd0);
    check_val("rst_odd_we",   32'(vram_odd_we), 32'd0);
    check_val("rst_ready",    32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Line 5, even bank, both requesters 3 beats each
    line_start  = 1'b1;
    line_no_in  = 10'd5;
    render_bank = 1'b0;
    set_req(2'b11, 2'b00, 10'd0, 8'hA0, 10'd100, 8'hB0);
    #1;
    check_val("idle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    line_start = 1'b0;
    check_val("l5_go", 32'(line_go), 32'd1);
    check_val("l5_line_no", 32'(line_no), 32'd5);
    check_val("start_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check_val("run_go_low", 32'(line_go), 32'd0);
    beat[0] = 0;
    beat[1] = 0;
    fin_m   = 2'b00;
    for (int c = 0; c < 6; c++) begin
      set_req(~fin_m, {beat[1] == 2, beat[0] == 2},
              10'(beat[0]), 8'(8'hA0 + beat[0]),
              10'(100 + beat[1]), 8'(8'hB0 + beat[1]));
      #1;
      check_val($sformatf("rr_grant_%0d", c), 32'(bus.req_ready), 32'(gtab[c]));
      for (int r = 0; r < 2; r++) begin
        if (gtab[c][r]) begin
          if (beat[r] == 2) fin_m[r] = 1'b1;
          beat[r]++;
        end
      end
      tick();
      check_val($sformatf("rr_even_we_%0d", c), 32'(vram_even_we), 32'd1);
      check_val($sformatf("rr_even_addr_%0d", c), 32'(vram_even_addr), 32'(atab[c]));
      check_val($sformatf("rr_even_d_%0d", c), 32'(vram_even_d), 32'(dtab[c]));
      check_val($sformatf("rr_odd_we_%0d", c), 32'(vram_odd_we), 32'd0);
      check_val($sformatf("rr_done_%0d", c), 32'(line_done), 32'(c == 5));
    end
    set_req(2'b00, 2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
    tick();
    check_val("done_pulse_end", 32'(line_done), 32'd0);
    check_val("done_even_we", 32'(vram_even_we), 32'd0);

    // Line 6, odd bank, one write addr 17 / 0xFF
    line_start  = 1'b1;
    line_no_in  = 10'd6;
    render_bank = 1'b1;
    tick();
    line_start = 1'b0;
    check_val("l6_go", 32'(line_go), 32'd1);
    check_val("l6_no_overrun", 32'(overrun_cnt), 32'd0);
    set_req(2'b01, 2'b01, 10'd17, 8'hFF, 10'd0, 8'd0);
    tick();
    check_val("odd_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check_val("odd_we", 32'(vram_odd_we), 32'd1);
    check_val("odd_addr", 32'(vram_odd_addr), 32'd17);
    check_val("odd_d", 32'(vram_odd_d), 32'hFF);
    check_val("odd_even_we", 32'(vram_even_we), 32'd0);
    check_val("odd_even_addr", 32'(vram_even_addr), 32'd0);
    check_val("odd_even_d", 32'(vram_even_d), 32'd0);
    check_val("odd_no_done", 32'(line_done), 32'd0);

    // Overrun: requester 1 still unfinished when line 7 starts
    set_req(2'b10, 2'b10, 10'd0, 8'd0, 10'd5, 8'h55);
    line_start  = 1'b1;
    line_no_in  = 10'd7;
    render_bank = 1'b0;
    #1;
    check_val("ovr_ready_masked", 32'(bus.req_ready), 32'd0);
    tick();
    line_start = 1'b0;
    check_val("ovr_cnt", 32'(overrun_cnt), 32'd1);
    check_val("ovr_go", 32'(line_go), 32'd1);
    check_val("ovr_no_done", 32'(line_done), 32'd0);
    check_val("ovr_line_no", 32'(line_no), 32'd7);
    check_val("ovr_no_odd_we", 32'(vram_odd_we), 32'd0);
    check_val("ovr_no_even_we", 32'(vram_even_we), 32'd0);
    set_req(2'b00, 2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
    tick();

    // Out-of-range address 800, then requester 1 finishes the line
    set_req(2'b01, 2'b01, 10'd800, 8'h5A, 10'd0, 8'd0);
    #1;
    check_val("oob_ready", 32'(bus.req_ready), 32'd1);
    tick();
`ifdef LINE_SCHED_BOUNDS_CHECK_EN
    check_val("oob_we", 32'(vram_even_we), 32'd0);
    check_val("oob_cnt", 32'(oob_cnt), 32'd1);
`else
    check_val("oob_we", 32'(vram_even_we), 32'd1);
    check_val("oob_addr", 32'(vram_even_addr), 32'd800);
    check_val("oob_d", 32'(vram_even_d), 32'h5A);
    check_val("oob_cnt", 32'(oob_cnt), 32'd0);
`endif
    set_req(2'b10, 2'b10, 10'd0, 8'd0, 10'd3, 8'h33);
    #1;
    check_val("l7_r1_ready", 32'(bus.req_ready), 32'd2);
    tick();
    check_val("l7_even_we", 32'(vram_even_we), 32'd1);
    check_val("l7_even_addr", 32'(vram_even_addr), 32'd3);
    check_val("l7_even_d", 32'(vram_even_d), 32'h33);
    check_val("l7_done", 32'(line_done), 32'd1);
    set_req(2'b00, 2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
    tick();

    // Reset during a write burst
    line_start  = 1'b1;
    line_no_in  = 10'd8;
    render_bank = 1'b1;
    tick();
    line_start = 1'b0;
    set_req(2'b11, 2'b00, 10'd40, 8'h11, 10'd41, 8'h22);
    tick();
    tick();
    check_val("burst_odd_we", 32'(vram_odd_we), 32'd1);
    check_val("burst_odd_addr", 32'(vram_odd_addr), 32'd40);
    rst_n = 1'b0;
    #1;
    check_val("arst_odd_we", 32'(vram_odd_we), 32'd0);
    check_val("arst_odd_addr", 32'(vram_odd_addr), 32'd0);
    check_val("arst_odd_d", 32'(vram_odd_d), 32'd0);
    check_val("arst_line_no", 32'(line_no), 32'd0);
    check_val("arst_overrun", 32'(overrun_cnt), 32'd0);
    check_val("arst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_ready", 32'(bus.req_ready), 32'd0);
    check_val("post_rst_go", 32'(line_go), 32'd0);
    check_val("post_rst_odd_we", 32'(vram_odd_we), 32'd0);
    set_req(2'b00, 2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
    line_start  = 1'b1;
    line_no_in  = 10'd9;
    render_bank = 1'b0;
    tick();
    line_start = 1'b0;
    check_val("post_rst_l9_go", 32'(line_go), 32'd1);
    check_val("post_rst_l9_no", 32'(line_no), 32'd9);
    check_val("post_rst_l9_ovr", 32'(overrun_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
